// File: rtl/arith_op_pkg.sv
// Shared encodings for the arithmetic sequencer: opcodes, FSM states, default width.
package arith_op_pkg;

  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per cycle, DATA_W cycles per divide.
module seq_divider #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic              busy;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] dvs_q;

  logic [DATA_W:0]   partial;
  logic [DATA_W:0]   diff;
  logic              fits;
  logic [DATA_W-1:0] rem_next;
  logic [DATA_W-1:0] quo_next;

  // quo_q doubles as the dividend shift register; its MSB feeds the partial remainder.
  always_comb begin
    partial  = {rem_q, quo_q[DATA_W-1]};
    diff     = partial - {1'b0, dvs_q};
    fits     = (partial >= {1'b0, dvs_q});
    rem_next = fits ? diff[DATA_W-1:0] : partial[DATA_W-1:0];
    quo_next = {quo_q[DATA_W-2:0], fits};
  end

  // done marks the cycle of the final step; quotient/remainder are that step's results.
  assign done      = busy && (cnt == LAST);
  assign quotient  = quo_next;
  assign remainder = rem_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= 1'b0;
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (busy) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
      cnt   <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/arith_op_sequencer.sv
// Single-request add/sub/mul/div sequencer with a valid/ready result hold.
// Divider is built only when ARITH_OP_SEQ_DIV_EN is defined.
module arith_op_sequencer
  import arith_op_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_value_a,
  input  logic [DATA_W-1:0] i_value_b,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_result,
  output logic [DATA_W-1:0] o_result_hi,
  output logic              o_error,
  output logic              o_busy
);

  // Handshakes: a request transfers on a rising edge with i_valid && o_ready;
  // a result transfers on a rising edge with o_valid && i_ready. Each side holds until then.

  state_e state, next_state;
  logic   accept;

  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;
  logic [2*DATA_W-1:0] prod;

  logic [DATA_W-1:0] res_lo;
  logic [DATA_W-1:0] res_hi;
  logic              res_err;

`ifdef ARITH_OP_SEQ_DIV_EN
  logic              div_start;
  logic              div_done;
  logic [DATA_W-1:0] div_quo;
  logic [DATA_W-1:0] div_rem;

  assign div_start = accept && (op_e'(i_op) == OP_DIV) && (i_value_b != '0);

  seq_divider #(.DATA_W(DATA_W)) u_div (
    .clk       (i_clk),
    .reset     (i_reset),
    .start     (div_start),
    .dividend  (i_value_a),
    .divisor   (i_value_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = i_valid && (state == ST_IDLE);
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
`ifdef ARITH_OP_SEQ_DIV_EN
          if (op_e'(i_op) == OP_DIV && i_value_b != '0) next_state = ST_DIV;
          else                                          next_state = ST_DONE;
`else
          next_state = ST_DONE;
`endif
        end
      end
`ifdef ARITH_OP_SEQ_DIV_EN
      ST_DIV:  if (div_done) next_state = ST_DONE;
`endif
      ST_DONE: if (i_ready) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    sum  = {1'b0, i_value_a} + {1'b0, i_value_b};
    diff = {1'b0, i_value_a} - {1'b0, i_value_b};
    prod = i_value_a * i_value_b;
  end

  // Result registers only change on accept or divider completion, so they hold outside DONE.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      res_lo  <= '0;
      res_hi  <= '0;
      res_err <= 1'b0;
    end else if (accept) begin
      res_err <= 1'b0;
      unique case (op_e'(i_op))
        OP_ADD: begin
          res_lo <= sum[DATA_W-1:0];
          res_hi <= {{(DATA_W-1){1'b0}}, sum[DATA_W]};
        end
        OP_SUB: begin
          res_lo <= diff[DATA_W-1:0];
          res_hi <= {{(DATA_W-1){1'b0}}, diff[DATA_W]};
        end
        OP_MUL: begin
          res_lo <= prod[DATA_W-1:0];
          res_hi <= prod[2*DATA_W-1:DATA_W];
        end
        OP_DIV: begin
`ifdef ARITH_OP_SEQ_DIV_EN
          if (i_value_b == '0) begin
            res_lo  <= '1;
            res_hi  <= i_value_a;
            res_err <= 1'b1;
          end
`else
          res_lo  <= '0;
          res_hi  <= '0;
          res_err <= 1'b1;
`endif
        end
      endcase
`ifdef ARITH_OP_SEQ_DIV_EN
    end else if (div_done) begin
      res_lo  <= div_quo;
      res_hi  <= div_rem;
      res_err <= 1'b0;
`endif
    end
  end

  assign o_ready     = (state == ST_IDLE);
  assign o_valid     = (state == ST_DONE);
  assign o_busy      = (state != ST_IDLE);
  assign o_result    = res_lo;
  assign o_result_hi = res_hi;
  assign o_error     = res_err;

endmodule

// File: doc/arith_op_sequencer.md
ARITH_OP_SEQUENCER -- requirements
Module: arith_op_sequencer

Interface
REQ-001 SHALL have parameter: DATA_W, 8, operand/result width (DATA_W >= 2).
REQ-002 SHALL have ports (name  direction  width  meaning):
  i_clk  input  1  single clock, rising edge.
  i_reset  input  1  synchronous, active-high reset.
  i_valid  input  1  request valid.
  o_ready  output  1  sequencer can accept a request.
  i_op  input  2  opcode: 0 add, 1 sub, 2 mul, 3 div.
  i_value_a  input  DATA_W  operand A, unsigned.
  i_value_b  input  DATA_W  operand B, unsigned.
  o_valid  output  1  result valid.
  i_ready  input  1  consumer accepts result.
  o_result  output  DATA_W  primary result.
  o_result_hi  output  DATA_W  auxiliary result (see REQ-009).
  o_error  output  1  result invalid (div by zero / div not built).
  o_busy  output  1  high in any state other than IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, DIV, DONE; o_ready = 1 only in IDLE.
REQ-004 SHALL accept a request on the cycle i_valid && o_ready; it SHALL capture i_op, i_value_a and i_value_b on that edge; inputs are don't-care otherwise.
REQ-005 add/sub/mul accept SHALL go IDLE->DONE; o_valid is high on the cycle after accept (latency 1).
REQ-006 div accept with B != 0 SHALL go IDLE->DIV; DIV lasts exactly DATA_W cycles, one restoring-division step per cycle, then DONE; o_valid is high DATA_W+1 cycles after accept.
REQ-007 div accept with B == 0 SHALL go IDLE->DONE; o_result = all ones, o_result_hi = A, o_error = 1.
REQ-008 In DONE, o_valid = 1 and o_result, o_result_hi and o_error SHALL hold stable until i_valid... until i_ready = 1; on the cycle o_valid && i_ready, the FSM SHALL go to IDLE. No new request is accepted in that same cycle.
REQ-009 Result widths: add: o_result = (A+B) mod 2^DATA_W, o_result_hi = carry-out in bit 0; sub: o_result = (A-B) mod 2^DATA_W, o_result_hi = borrow in bit 0; mul: {o_result_hi, o_result} = full 2*DATA_W product; div: o_result = quotient, o_result_hi = remainder. o_error = 0 except in REQ-007 and REQ-012.
REQ-010 Outside DONE, o_valid SHALL be 0; o_result, o_result_hi and o_error SHALL keep their last values.

Reset
REQ-011 i_reset high at any clock edge, including mid-DIV or mid-DONE, SHALL force IDLE and abort any operation. After that edge o_valid = 0, o_ready = 1, o_busy = 0, o_error = 0, o_result = 0, o_result_hi = 0, and all divider state = 0. Any request presented during reset is not accepted.

Configuration
REQ-012 Macro ARITH_OP_SEQ_DIV_EN: when defined, div SHALL behave per REQ-006/007. When undefined, the divider SHALL NOT be instantiated, no DIV state logic exists, and an op 3 request SHALL go IDLE->DONE with o_result = 0, o_result_hi = 0, o_error = 1.

Structure
REQ-013 Shared package arith_op_pkg SHALL hold the opcode encoding (OP_ADD, OP_SUB, OP_MUL, OP_DIV), the FSM state encoding, and the DATA_W default.
REQ-014 Sub-module seq_divider SHALL hold the iterative restoring divider. It has start, done, quotient and remainder, and is instantiated only under ARITH_OP_SEQ_DIV_EN.

Verification
REQ-015 add A = 200, B = 100 -> o_valid 1 cycle after accept; o_result = 44, o_result_hi = 1, o_error = 0.
REQ-016 sub A = 5, B = 10 -> o_result = 251, o_result_hi = 1. mul A = 20, B = 30 -> o_result = 88, o_result_hi = 2.
REQ-017 div A = 200, B = 7 -> o_valid exactly 9 cycles after accept; o_result = 28, o_result_hi = 4, o_busy high throughout.
REQ-018 div A = 13, B = 0 -> o_valid 1 cycle after accept; o_result = 255, o_result_hi = 13, o_error = 1. With the macro undefined, div 200/7 -> o_result = 0, o_error = 1.
REQ-019 Backpressure: i_ready low for 3 cycles in DONE -> outputs stable, o_ready = 0 throughout, and a request presented meanwhile is not accepted. After the i_ready handshake, o_ready = 1 on the next cycle.
REQ-020 i_reset asserted on the 4th cycle of DIV for 200/7 -> next cycle IDLE with all outputs per REQ-011. A following add 1+1 -> o_result = 2.
